// File: rtl/exc_mem_stage.sv
// Memory-stage exception resolver: flags bad data-memory/timer accesses, merges them with
// earlier-stage exceptions, pipelines the result into W and captures EPC/BadVAddr.
module exc_mem_stage #(
  parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] TC_SPAN  = 32'd12,
  parameter logic [31:0] CNT_OFF  = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallW,
  input  logic        FlushW,
  input  logic [31:0] PCM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [2:0]  MemOpM,
  input  logic [31:0] Address,
  input  logic        AddrOvM,
  input  logic        ExcValidM,
  input  logic [4:0]  ExcCodeM,
  input  logic        ExcAck,
  output logic        ExcValidW,
  output logic [4:0]  ExcCodeW,
  output logic [31:0] EPC,
  output logic [31:0] BadVAddr,
  output logic        ExcPending,
  output logic        MemWriteSafeM
);

  localparam logic [31:0] TC0_LAST = TC0_BASE + TC_SPAN - 32'd1;
  localparam logic [31:0] TC1_LAST = TC1_BASE + TC_SPAN - 32'd1;
  localparam logic [4:0]  CODE_ADEL = 5'd4;
  localparam logic [4:0]  CODE_ADES = 5'd5;

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state_q;
  logic        excValidW_q;
  logic [4:0]  excCodeW_q;
  logic [31:0] epc_q;
  logic [31:0] badVAddr_q;

  logic        isWord, isHalf;
  logic        inDm, inTc0, inTc1, inTimer, isCntReg;
  logic        misaligned, badAccess, memExc;
  logic        excValid_d;
  logic [4:0]  excCode_d;
  logic [31:0] badVAddr_d;
  logic        wLoad, capture;

  // MemOpM[2] is the load sign bit and has no bearing on address checking
  assign isWord     = (MemOpM[1:0] == 2'd0);
  assign isHalf     = (MemOpM[1:0] == 2'd1);
  assign misaligned = (isWord && (Address[1:0] != 2'b00)) || (isHalf && Address[0]);

  assign inDm     = (Address <= DM_TOP);
  assign inTc0    = (Address >= TC0_BASE) && (Address <= TC0_LAST);
  assign inTc1    = (Address >= TC1_BASE) && (Address <= TC1_LAST);
  assign inTimer  = inTc0 || inTc1;
  assign isCntReg = (Address == TC0_BASE + CNT_OFF) || (Address == TC1_BASE + CNT_OFF);

  assign badAccess = misaligned || AddrOvM || !(inDm || inTimer)
                     || (inTimer && !isWord) || (MemWriteM && isCntReg);
  assign memExc    = badAccess && (MemtoRegM || MemWriteM);

  always_comb begin
    excValid_d = 1'b0;
    excCode_d  = 5'd0;
    badVAddr_d = 32'd0;
    if (ExcValidM) begin
      excValid_d = 1'b1;
      excCode_d  = ExcCodeM;
    end else if (memExc) begin
      excValid_d = 1'b1;
      excCode_d  = MemtoRegM ? CODE_ADEL : CODE_ADES;
      badVAddr_d = Address;
    end
  end

  assign MemWriteSafeM = MemWriteM && !(excValid_d || ExcPending);

  // A new exception is captured when W loads and the handler slot is free or being released now
  assign wLoad   = !StallW && !FlushW;
  assign capture = wLoad && excValid_d && ((state_q == IDLE) || ExcAck);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      excValidW_q <= 1'b0;
      excCodeW_q  <= 5'd0;
      epc_q       <= 32'd0;
      badVAddr_q  <= 32'd0;
    end else begin
      if (FlushW) begin
        excValidW_q <= 1'b0;
        excCodeW_q  <= 5'd0;
      end else if (!StallW) begin
        excValidW_q <= excValid_d;
        excCodeW_q  <= excCode_d;
      end
      if (capture) begin
        state_q    <= PEND;
        epc_q      <= PCM;
        badVAddr_q <= badVAddr_d;
      end else if (ExcAck) begin
        state_q <= IDLE;
      end
    end
  end

  assign ExcValidW  = excValidW_q;
  assign ExcCodeW   = excCodeW_q;
  assign EPC        = epc_q;
  assign BadVAddr   = badVAddr_q;
  assign ExcPending = (state_q == PEND);

endmodule

// File: tb/tb_exc_mem_stage.sv
// Directed bench for exc_mem_stage with hand-computed expected values.
module tb_exc_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallW, FlushW;
  logic [31:0] PCM;
  logic        MemtoRegM, MemWriteM;
  logic [2:0]  MemOpM;
  logic [31:0] Address;
  logic        AddrOvM;
  logic        ExcValidM;
  logic [4:0]  ExcCodeM;
  logic        ExcAck;
  logic        ExcValidW;
  logic [4:0]  ExcCodeW;
  logic [31:0] EPC, BadVAddr;
  logic        ExcPending, MemWriteSafeM;

  int checks = 0;
  int errors = 0;

  exc_mem_stage dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .PCM(PCM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .MemOpM(MemOpM), .Address(Address),
    .AddrOvM(AddrOvM), .ExcValidM(ExcValidM), .ExcCodeM(ExcCodeM), .ExcAck(ExcAck),
    .ExcValidW(ExcValidW), .ExcCodeW(ExcCodeW), .EPC(EPC), .BadVAddr(BadVAddr),
    .ExcPending(ExcPending), .MemWriteSafeM(MemWriteSafeM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] pc,
                               input logic ov, input logic ev, input logic [4:0] ec,
                               input logic ack, input logic stall, input logic flush);
    MemtoRegM = ld;  MemWriteM = st;  MemOpM = op;  Address = addr;  PCM = pc;
    AddrOvM = ov;  ExcValidM = ev;  ExcCodeM = ec;  ExcAck = ack;
    StallW = stall;  FlushW = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0);
    #1;
    checkOutput("rstValid", ExcValidW, 0);
    checkOutput("rstCode", ExcCodeW, 0);
    checkOutput("rstEpc", EPC, 0);
    checkOutput("rstBad", BadVAddr, 0);
    checkOutput("rstPend", ExcPending, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    checkOutput("postRstPend", ExcPending, 0);

    // misaligned half store outside every window
    applyStimulus(0, 1, 3'd1, 32'h7FFF, 32'h3000, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("t1Safe", MemWriteSafeM, 0);
    tick();
    checkOutput("t1Valid", ExcValidW, 1);
    checkOutput("t1Code", ExcCodeW, 5);
    checkOutput("t1Epc", EPC, 32'h3000);
    checkOutput("t1Bad", BadVAddr, 32'h7FFF);
    checkOutput("t1Pend", ExcPending, 1);

    applyStimulus(0, 1, 3'd0, 32'h0100, 32'h3004, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("pendSafe", MemWriteSafeM, 0);

    // second bad load while pending must not overwrite the capture
    applyStimulus(1, 0, 3'd0, 32'h0001, 32'h3004, 0, 0, 5'd0, 0, 0, 0);
    tick();
    checkOutput("t2Code", ExcCodeW, 4);
    checkOutput("t2Epc", EPC, 32'h3000);
    checkOutput("t2Bad", BadVAddr, 32'h7FFF);
    checkOutput("t2Pend", ExcPending, 1);

    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
    tick();
    checkOutput("ackPend", ExcPending, 0);
    checkOutput("ackValid", ExcValidW, 0);
    checkOutput("ackEpcHeld", EPC, 32'h3000);

    applyStimulus(1, 0, 3'd0, 32'h7F08, 32'h3008, 0, 0, 5'd0, 0, 0, 0);
    tick();
    checkOutput("cntLoadValid", ExcValidW, 0);
    checkOutput("cntLoadPend", ExcPending, 0);

    applyStimulus(0, 1, 3'd0, 32'h7F08, 32'h3008, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("cntStoreSafe", MemWriteSafeM, 0);
    tick();
    checkOutput("cntStoreCode", ExcCodeW, 5);
    checkOutput("cntStoreBad", BadVAddr, 32'h7F08);
    checkOutput("cntStoreEpc", EPC, 32'h3008);
    checkOutput("cntStorePend", ExcPending, 1);

    // ack and new capture on the same edge
    applyStimulus(1, 0, 3'd2, 32'h7F14, 32'h300C, 0, 0, 5'd0, 1, 0, 0);
    tick();
    checkOutput("ackNewCode", ExcCodeW, 4);
    checkOutput("ackNewPend", ExcPending, 1);
    checkOutput("ackNewEpc", EPC, 32'h300C);
    checkOutput("ackNewBad", BadVAddr, 32'h7F14);

    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
    tick();
    checkOutput("ack2Pend", ExcPending, 0);

    applyStimulus(0, 1, 3'd0, 32'h2FFC, 32'h3010, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("dmTopSafe", MemWriteSafeM, 1);
    tick();
    checkOutput("dmTopValid", ExcValidW, 0);
    checkOutput("dmTopPend", ExcPending, 0);

    applyStimulus(1, 0, 3'd2, 32'h3000, 32'h3014, 0, 0, 5'd0, 0, 0, 0);
    tick();
    checkOutput("pastDmCode", ExcCodeW, 4);
    checkOutput("pastDmBad", BadVAddr, 32'h3000);
    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
    tick();
    checkOutput("ack3Pend", ExcPending, 0);

    // earlier-stage exception wins over the bad load
    applyStimulus(1, 0, 3'd0, 32'h0001, 32'h3018, 0, 1, 5'd12, 0, 0, 0);
    tick();
    checkOutput("prioValid", ExcValidW, 1);
    checkOutput("prioCode", ExcCodeW, 12);
    checkOutput("prioBad", BadVAddr, 0);
    checkOutput("prioEpc", EPC, 32'h3018);

    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 1, 0);
    tick();
    checkOutput("stallValid", ExcValidW, 1);
    checkOutput("stallCode", ExcCodeW, 12);
    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 1, 1);
    tick();
    checkOutput("flushValid", ExcValidW, 0);
    checkOutput("flushCode", ExcCodeW, 0);
    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
    tick();
    checkOutput("ack4Pend", ExcPending, 0);

    // overflowing store held by stall, then flushed: never captured
    applyStimulus(0, 1, 3'd0, 32'h0100, 32'h301C, 1, 0, 5'd0, 0, 1, 0);
    checkOutput("ovSafe0", MemWriteSafeM, 0);
    tick();
    checkOutput("ovValid1", ExcValidW, 0);
    checkOutput("ovSafe1", MemWriteSafeM, 0);
    tick();
    checkOutput("ovValid2", ExcValidW, 0);
    applyStimulus(0, 1, 3'd0, 32'h0100, 32'h301C, 1, 0, 5'd0, 0, 0, 1);
    checkOutput("ovSafe2", MemWriteSafeM, 0);
    tick();
    checkOutput("ovValid3", ExcValidW, 0);
    checkOutput("ovPend", ExcPending, 0);
    checkOutput("ovEpc", EPC, 32'h3018);

    // asynchronous reset in the middle of a pending capture
    applyStimulus(1, 0, 3'd2, 32'h3000, 32'h3020, 0, 0, 5'd0, 0, 0, 0);
    tick();
    checkOutput("preRstPend", ExcPending, 1);
    applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    checkOutput("asyncValid", ExcValidW, 0);
    checkOutput("asyncCode", ExcCodeW, 0);
    checkOutput("asyncEpc", EPC, 0);
    checkOutput("asyncBad", BadVAddr, 0);
    checkOutput("asyncPend", ExcPending, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    checkOutput("afterRstPend", ExcPending, 0);
    checkOutput("afterRstEpc", EPC, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
